// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive front-end with a show-ahead byte FIFO.
// Synchronizes uart_rx, deserializes 8N1 frames sampled at mid-bit and
// buffers received bytes for a read-strobe consumer with sticky error flags.
// Optional build macro UART_RX_PARITY_EN switches to 8E1 frames, adds a
// PARITY state and the sticky parity_err output; bytes with bad parity are
// dropped.
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 8,
   parameter int CNT_W        = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             uart_rx,
   input  logic             rd_en,
   input  logic             err_clr,
   output logic [7:0]       rd_data,
   output logic             rx_valid,
   output logic [CNT_W-1:0] fifo_count,
   output logic             frame_err,
   output logic             overrun_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic             parity_err
`endif
);

   localparam int               PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [15:0]      BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0]      HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
`ifdef UART_RX_PARITY_EN
      ,
      PARITY
`endif
   } state_t;

   state_t           state;
   logic             sync_p0;
   logic             rxs;
   logic [15:0]      baud_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             baud_done;
   logic             data_tick;
   logic             stop_tick;
   logic             push;
   logic             frame_evt;
   logic             do_pop;
   logic             do_push;
   logic             overrun_evt;
   logic             full;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [7:0]       mem [FIFO_DEPTH];

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic par_tick;
   logic par_evt;

   assign par_tick = (state == PARITY) && baud_done;
   // Even parity: data bits XOR parity bit must be zero.
   assign par_evt  = stop_tick && ((^shift_reg) ^ par_bit);
   assign push     = stop_tick && rxs && !par_evt;
`else
   assign push     = stop_tick && rxs;
`endif

   assign baud_done = (baud_cnt == BIT_LAST);
   assign data_tick = (state == DATA) && baud_done;
   assign stop_tick = (state == STOP) && baud_done;
   assign frame_evt = stop_tick && !rxs;

   // A pop on an empty FIFO is ignored; a push into a full FIFO succeeds
   // only when a pop frees the head slot in the same cycle.
   assign full        = (fifo_count == FULL_CNT);
   assign rx_valid    = (fifo_count != '0);
   assign do_pop      = rd_en && rx_valid;
   assign do_push     = push && (!full || do_pop);
   assign overrun_evt = push && full && !do_pop;
   assign rd_data     = rx_valid ? mem[rd_ptr] : 8'h00;

   // Two-flop synchronizer, preset to the idle (high) line level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_p0 <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         sync_p0 <= uart_rx;
         rxs     <= sync_p0;
      end
   end

   // Frame FSM: start-bit qualification at half a bit, then one sample per bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
               if (!rxs) state <= START;
            end
            START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  state    <= rxs ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            DATA: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  bit_cnt  <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
`endif
            STOP: begin
               if (baud_done) begin
                  baud_cnt <= '0;
                  state    <= rxs ? IDLE : WAIT_HIGH;
               end else begin
                  baud_cnt <= baud_cnt + 16'd1;
               end
            end
            WAIT_HIGH: begin
               // Hold off until the line returns high so a break is not
               // taken as a stream of zero frames.
               if (rxs) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Data bits shift in LSB first; this register carries no reset.
   always_ff @(posedge clk) begin
      if (data_tick) shift_reg <= {rxs, shift_reg[7:1]};
   end

`ifdef UART_RX_PARITY_EN
   // Capture the parity bit at its mid-bit sample.
   always_ff @(posedge clk) begin
      if (par_tick) par_bit <= rxs;
   end
`endif

   // FIFO storage write; contents are not reset, only the pointers are.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= shift_reg;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err  <= 1'b0;
`endif
      end else begin
         if (frame_evt)    frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (overrun_evt)  overrun_err <= 1'b1;
         else if (err_clr) overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         if (par_evt)      parity_err <= 1'b1;
         else if (err_clr) parity_err <= 1'b0;
`endif
      end
   end

endmodule
